rr_sel8: RTL

Eight-way round-robin requester selector sitting directly upstream of the 3-to-8 decoder. Arbitrates an 8-bit request vector and drives the decoder's 3-bit select and enable, so the decoder's one-hot output is the registered grant. Each grant is held until the owner releases it. A turnaround cycle is inserted between grants so the decoder output never switches directly between two owners.

---
 rtl/rr_sel8_if.sv | 24 ++
 rtl/rr_sel8.sv | 127 ++++++++++++
 2 files changed

// File: rtl/rr_sel8_if.sv
// rtl/rr_sel8_if.sv - request/grant bundle between requesters and the rr_sel8 selector
interface rr_sel8_if;
  logic [7:0] req;
  logic       done;
  logic [2:0] a;
  logic       e;
  logic       tmo;

  modport master (
    output req,
    output done,
    input  a,
    input  e,
    input  tmo
  );

  modport slave (
    input  req,
    input  done,
    output a,
    output e,
    output tmo
  );
endinterface

// File: rtl/rr_sel8.sv
// rtl/rr_sel8.sv - eight-way round-robin selector driving a 3-to-8 decoder (a/e)
// Optional forced release after TIMEOUT grant cycles when RR_SEL8_TIMEOUT_EN is defined.
module rr_sel8 #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic     clk,
  input  logic     rst_n,
  rr_sel8_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] a_q, a_d;
  logic [2:0] ptr_q, ptr_d;
  logic       e_q, e_d;
  logic [2:0] win;
  logic       hit;
  logic       rel;

`ifdef RR_SEL8_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       tmo_q, tmo_d;
  logic       expire;

  assign expire = (cnt_q >= 8'(TIMEOUT - 1));
`else
  wire [7:0] unused_timeout = 8'(TIMEOUT);
`endif

  // Search starts just past the last owner, so the previous winner ranks last.
  always_comb begin
    logic [2:0] idx;
    win = ptr_q;
    hit = 1'b0;
    idx = 3'd0;
    for (int i = 1; i <= 8; i++) begin
      idx = ptr_q + 3'(i);
      if (!hit && bus.req[idx]) begin
        win = idx;
        hit = 1'b1;
      end
    end
  end

  assign rel = bus.done || !bus.req[a_q];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    ptr_d   = ptr_q;
    e_d     = e_q;
`ifdef RR_SEL8_TIMEOUT_EN
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (hit) begin
          a_d     = win;
          ptr_d   = win;
          e_d     = 1'b1;
          state_d = GRANT;
`ifdef RR_SEL8_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end else begin
          e_d = 1'b0;
        end
      end
      GRANT: begin
        // A normal release outranks the timeout, so tmo only marks forced releases.
        if (rel) begin
          e_d     = 1'b0;
          state_d = IDLE;
        end
`ifdef RR_SEL8_TIMEOUT_EN
        else if (expire) begin
          e_d     = 1'b0;
          tmo_d   = 1'b1;
          state_d = IDLE;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      default: begin
        e_d     = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= 3'd0;
      ptr_q   <= 3'd7;
      e_q     <= 1'b0;
`ifdef RR_SEL8_TIMEOUT_EN
      cnt_q   <= 8'd0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      ptr_q   <= ptr_d;
      e_q     <= e_d;
`ifdef RR_SEL8_TIMEOUT_EN
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign bus.a = a_q;
  assign bus.e = e_q;
`ifdef RR_SEL8_TIMEOUT_EN
  assign bus.tmo = tmo_q;
`else
  assign bus.tmo = 1'b0;
`endif

endmodule
